branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Execute-stage branch/redirect resolution unit.
- Compares each branch's real outcome with the prediction bit carried down from the fetch stage, and produces the registered jump_cause / jump_from / jump_to triple that drives the PC redirect and predictor update.
- Also arbitrates exception, interrupt and unconditional jumps onto that interface.
- Squashes wrong-path instructions after a redirect and keeps branch/mispredict statistics.

Parameters:
FLUSH_CYCLES, 2, non-held cycles after a redirect during which incoming EX instructions are wrong-path and ignored (1..7).
CNT_WIDTH, 32, width of the statistics counters.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low (`rst_enable)
jtag_reset_i  in  1  synchronous reset, `jtag_rst_enable; same effect as rst_n
hold_flag_i  in  `holdpip_bus  pipeline hold; EX instruction not consumed unless == `hold_no
ex_valid_i  in  1  EX holds a valid instruction
ex_inst_i  in  `inst_bus  instruction word in EX
ex_pc_i  in  `inst_addr_bus  address of the EX instruction
ex_predict_jump_i  in  1  prediction bit from fetch, pipelined (`predict_jump_enable = predicted taken)
rs1_data_i  in  32  operand rs1
rs2_data_i  in  32  operand rs2
exc_req_i  in  1  EX instruction raises an exception
exc_vector_i  in  `inst_addr_bus  exception handler address
int_req_i  in  1  level interrupt request
int_vector_i  in  `inst_addr_bus  interrupt handler address
jump_cause_o  out  `jump_cause_bus  redirect cause; `jump_cause_no when idle
jump_from_addr_o  out  `inst_addr_bus  address of the resolving instruction
jump_to_addr_o  out  `inst_addr_bus  redirect target
flush_o  out  1  high while in FLUSH state
branch_cnt_o  out  CNT_WIDTH  resolved conditional branches
mispredict_cnt_o  out  CNT_WIDTH  mispredicted conditional branches

Behaviour:
- Reset (rst_n low or jtag_reset_i active at posedge):
  - jump_cause_o=`jump_cause_no; jump_from_addr_o=0; jump_to_addr_o=0.
  - flush_o=0; both counters=0; FSM=RUN; flush counter=0.
  - Reset mid-FLUSH aborts the flush.
- Consume condition: consume = ex_valid_i && hold_flag_i==`hold_no && state==RUN.
- Decoding:
  - Branch: opcode==`inst_b. funct3 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU. funct3 010/011: not a branch, no action.
  - imm_b = sign-extended {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - JAL target: ex_pc_i + sign-extended J-immediate.
  - JALR target: (rs1_data_i + sign-extended I-immediate) & ~1.
  - Target additions wrap modulo 2^`inst_addr_bus_width.
- Priority when consume, evaluated in one cycle; all outputs registered, so they appear on the next posedge (latency 1):
  1. exc_req_i: cause `jump_cause_exception, to=exc_vector_i.
  2. int_req_i: cause `jump_cause_interrupt, to=int_vector_i.
  3. JAL/JALR: cause `jump_cause_nocondition, to=target.
  4. Branch, taken && !predict: cause `jump_cause_predict_no_but_yes, to=ex_pc_i+imm_b.
  5. Branch, !taken && predict: cause `jump_cause_predict_yes_but_no, to=ex_pc_i+4.
  6. Otherwise: `jump_cause_no.
- jump_from_addr_o=ex_pc_i for every non-no cause. jump_from_addr_o and jump_to_addr_o hold their last values when the cause is no.
- jump_cause_o is a one-cycle pulse; it returns to `jump_cause_no the cycle after. A pulse occurring while hold_flag_i is active is still emitted, because PC gives jumps priority over hold.
- Counters:
  - branch_cnt_o increments on every consumed conditional branch when no exception or interrupt won arbitration.
  - mispredict_cnt_o increments on cases 4 and 5.
  - Both saturate at all-ones.
- FSM:
  - RUN -> FLUSH on any non-no cause; counter loads FLUSH_CYCLES.
  - FLUSH: flush_o=1; ex_valid_i ignored, including exc_req_i. The counter decrements only in cycles with hold_flag_i==`hold_no. On reaching 0 -> RUN, and flush_o=0 in the same cycle as RUN.
  - An interrupt during FLUSH is not taken. int_req_i is level, so it is accepted on the first consumed instruction after return to RUN.
- No back-to-back redirects: a new redirect needs at least FLUSH_CYCLES+1 cycles after the previous pulse.

Test Plan:
- BEQ at pc=0x100, imm=+0x20, rs1=rs2=5, predict=0 -> next cycle cause=predict_no_but_yes, from=0x100, to=0x120; flush_o high 2 cycles; branch_cnt=1, mispredict_cnt=1.
- BLT pc=0x200, rs1=0xFFFFFFFF, rs2=1, predict=1 -> taken, correct prediction: cause=no, branch_cnt+1, mispredict unchanged. The same operands with BLTU -> not taken -> cause=predict_yes_but_no, to=0x204.
- Instruction with exc_req_i=1 and int_req_i=1, and the instruction is a mispredicted BNE -> cause=exception, to=exc_vector_i, branch_cnt unchanged. Release the flush; int_req_i still high on the next consumed instruction -> cause=interrupt.
- JALR rs1=0x1003, imm=+4 -> to=0x1006 (bit0 cleared), cause=nocondition. Valid instructions during the next 2 cycles, one with exc_req_i=1 -> no cause emitted.
- Redirect, then hold_flag_i active for 3 cycles during FLUSH -> flush_o stays high 3+2 cycles; assert rst_n low mid-flush -> all outputs at reset values next cycle.
- Preload mispredict_cnt to all-ones (CNT_WIDTH=4 build) and issue a mispredict -> count stays 0xF.

Source files
------------

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: compares branch outcome with the fetch prediction, arbitrates
// exception/interrupt/jump redirects, squashes wrong-path instructions and counts mispredicts.
module branch_resolve #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 jtag_reset_i,
  input  logic [2:0]           hold_flag_i,
  input  logic                 ex_valid_i,
  input  logic [31:0]          ex_inst_i,
  input  logic [31:0]          ex_pc_i,
  input  logic                 ex_predict_jump_i,
  input  logic [31:0]          rs1_data_i,
  input  logic [31:0]          rs2_data_i,
  input  logic                 exc_req_i,
  input  logic [31:0]          exc_vector_i,
  input  logic                 int_req_i,
  input  logic [31:0]          int_vector_i,
  output logic [2:0]           jump_cause_o,
  output logic [31:0]          jump_from_addr_o,
  output logic [31:0]          jump_to_addr_o,
  output logic                 flush_o,
  output logic [CNT_WIDTH-1:0] branch_cnt_o,
  output logic [CNT_WIDTH-1:0] mispredict_cnt_o
);

  localparam logic [2:0] HoldNo                = 3'b000;
  localparam logic [6:0] InstB                 = 7'b1100011;
  localparam logic [6:0] InstJal               = 7'b1101111;
  localparam logic [6:0] InstJalr              = 7'b1100111;
  localparam logic [2:0] CauseNo               = 3'd0;
  localparam logic [2:0] CauseException        = 3'd1;
  localparam logic [2:0] CauseInterrupt        = 3'd2;
  localparam logic [2:0] CauseNoCondition      = 3'd3;
  localparam logic [2:0] CausePredictNoButYes  = 3'd4;
  localparam logic [2:0] CausePredictYesButNo  = 3'd5;

  typedef enum logic {StRun, StFlush} state_e;

  state_e               state_q;
  logic [2:0]           flush_cnt_q;
  logic [2:0]           jump_cause_q;
  logic [31:0]          jump_from_q;
  logic [31:0]          jump_to_q;
  logic [CNT_WIDTH-1:0] branch_cnt_q;
  logic [CNT_WIDTH-1:0] mispredict_cnt_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_b, imm_j, imm_i;
  logic        consume, is_branch, taken, count_branch, count_mispredict;
  logic [2:0]  cause_d;
  logic [31:0] target_d;

  assign opcode  = ex_inst_i[6:0];
  assign funct3  = ex_inst_i[14:12];
  assign imm_b   = {{19{ex_inst_i[31]}}, ex_inst_i[31], ex_inst_i[7], ex_inst_i[30:25],
                    ex_inst_i[11:8], 1'b0};
  assign imm_j   = {{11{ex_inst_i[31]}}, ex_inst_i[31], ex_inst_i[19:12], ex_inst_i[20],
                    ex_inst_i[30:21], 1'b0};
  assign imm_i   = {{20{ex_inst_i[31]}}, ex_inst_i[31:20]};
  assign consume = ex_valid_i && (hold_flag_i == HoldNo) && (state_q == StRun);

  always_comb begin
    is_branch = 1'b0;
    taken     = 1'b0;
    case (funct3)
      3'b000:  begin is_branch = 1'b1; taken = (rs1_data_i == rs2_data_i); end
      3'b001:  begin is_branch = 1'b1; taken = (rs1_data_i != rs2_data_i); end
      3'b100:  begin is_branch = 1'b1; taken = ($signed(rs1_data_i) <  $signed(rs2_data_i)); end
      3'b101:  begin is_branch = 1'b1; taken = ($signed(rs1_data_i) >= $signed(rs2_data_i)); end
      3'b110:  begin is_branch = 1'b1; taken = (rs1_data_i <  rs2_data_i); end
      3'b111:  begin is_branch = 1'b1; taken = (rs1_data_i >= rs2_data_i); end
      default: ;
    endcase
    if (opcode != InstB) is_branch = 1'b0;
  end

  always_comb begin
    cause_d          = CauseNo;
    target_d         = jump_to_q;
    count_branch     = 1'b0;
    count_mispredict = 1'b0;
    if (consume) begin
      if (exc_req_i) begin
        cause_d  = CauseException;
        target_d = exc_vector_i;
      end else if (int_req_i) begin
        cause_d  = CauseInterrupt;
        target_d = int_vector_i;
      end else if (opcode == InstJal) begin
        cause_d  = CauseNoCondition;
        target_d = ex_pc_i + imm_j;
      end else if (opcode == InstJalr) begin
        cause_d  = CauseNoCondition;
        target_d = (rs1_data_i + imm_i) & ~32'd1;
      end else if (is_branch) begin
        count_branch = 1'b1;
        if (taken && !ex_predict_jump_i) begin
          cause_d          = CausePredictNoButYes;
          target_d         = ex_pc_i + imm_b;
          count_mispredict = 1'b1;
        end else if (!taken && ex_predict_jump_i) begin
          cause_d          = CausePredictYesButNo;
          target_d         = ex_pc_i + 32'd4;
          count_mispredict = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || jtag_reset_i) begin
      state_q          <= StRun;
      flush_cnt_q      <= 3'd0;
      jump_cause_q     <= CauseNo;
      jump_from_q      <= 32'd0;
      jump_to_q        <= 32'd0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      jump_cause_q <= CauseNo;
      unique case (state_q)
        StRun: begin
          if (cause_d != CauseNo) begin
            jump_cause_q <= cause_d;
            jump_from_q  <= ex_pc_i;
            jump_to_q    <= target_d;
            state_q      <= StFlush;
            flush_cnt_q  <= 3'(FLUSH_CYCLES);
          end
        end
        StFlush: begin
          // Held cycles do not advance the squash window.
          if (hold_flag_i == HoldNo) begin
            if (flush_cnt_q <= 3'd1) begin
              flush_cnt_q <= 3'd0;
              state_q     <= StRun;
            end else begin
              flush_cnt_q <= flush_cnt_q - 3'd1;
            end
          end
        end
        default: state_q <= StRun;
      endcase
      if (count_branch && (branch_cnt_q != '1)) begin
        branch_cnt_q <= branch_cnt_q + CNT_WIDTH'(1);
      end
      if (count_mispredict && (mispredict_cnt_q != '1)) begin
        mispredict_cnt_q <= mispredict_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign jump_cause_o     = jump_cause_q;
  assign jump_from_addr_o = jump_from_q;
  assign jump_to_addr_o   = jump_to_q;
  assign flush_o          = (state_q == StFlush);
  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed vectors push expected post-edge state, a monitor
// pops and compares. A CNT_WIDTH=4 copy shares the stimulus to exercise counter saturation.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n, jtag_reset_i;
  logic [2:0]  hold_flag_i;
  logic        ex_valid_i, ex_predict_jump_i, exc_req_i, int_req_i;
  logic [31:0] ex_inst_i, ex_pc_i, rs1_data_i, rs2_data_i, exc_vector_i, int_vector_i;
  logic [2:0]  jump_cause_o;
  logic [31:0] jump_from_addr_o, jump_to_addr_o;
  logic        flush_o;
  logic [31:0] branch_cnt_o, mispredict_cnt_o;

  logic [2:0]  unused_cause4;
  logic [31:0] unused_from4, unused_to4;
  logic        unused_flush4;
  logic [3:0]  branch_cnt4, mispredict_cnt4;

  always #5 clk = ~clk;

  branch_resolve #(.FLUSH_CYCLES(2), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .jtag_reset_i(jtag_reset_i), .hold_flag_i(hold_flag_i),
    .ex_valid_i(ex_valid_i), .ex_inst_i(ex_inst_i), .ex_pc_i(ex_pc_i),
    .ex_predict_jump_i(ex_predict_jump_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .exc_req_i(exc_req_i), .exc_vector_i(exc_vector_i), .int_req_i(int_req_i),
    .int_vector_i(int_vector_i), .jump_cause_o(jump_cause_o),
    .jump_from_addr_o(jump_from_addr_o), .jump_to_addr_o(jump_to_addr_o), .flush_o(flush_o),
    .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
  );

  branch_resolve #(.FLUSH_CYCLES(2), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .jtag_reset_i(jtag_reset_i), .hold_flag_i(hold_flag_i),
    .ex_valid_i(ex_valid_i), .ex_inst_i(ex_inst_i), .ex_pc_i(ex_pc_i),
    .ex_predict_jump_i(ex_predict_jump_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .exc_req_i(exc_req_i), .exc_vector_i(exc_vector_i), .int_req_i(int_req_i),
    .int_vector_i(int_vector_i), .jump_cause_o(unused_cause4),
    .jump_from_addr_o(unused_from4), .jump_to_addr_o(unused_to4), .flush_o(unused_flush4),
    .branch_cnt_o(branch_cnt4), .mispredict_cnt_o(mispredict_cnt4)
  );

  localparam logic [2:0] NO = 3'd0, EXC = 3'd1, INT = 3'd2, NOC = 3'd3, PNBY = 3'd4,
                         PYBN = 3'd5;

  typedef struct {
    int          due;
    logic [2:0]  cause;
    logic [31:0] from;
    logic [31:0] to;
    logic        flush;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
    logic [3:0]  bcnt4;
    logic [3:0]  mcnt4;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      chk("jump_cause", {29'd0, jump_cause_o}, {29'd0, mon_e.cause});
      chk("jump_from", jump_from_addr_o, mon_e.from);
      chk("jump_to", jump_to_addr_o, mon_e.to);
      chk("flush", {31'd0, flush_o}, {31'd0, mon_e.flush});
      chk("branch_cnt", branch_cnt_o, mon_e.bcnt);
      chk("mispredict_cnt", mispredict_cnt_o, mon_e.mcnt);
      chk("branch_cnt_w4", {28'd0, branch_cnt4}, {28'd0, mon_e.bcnt4});
      chk("mispredict_cnt_w4", {28'd0, mispredict_cnt4}, {28'd0, mon_e.mcnt4});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
    return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [3:0] sat4(input int v);
    return (v > 15) ? 4'hF : 4'(v);
  endfunction

  task automatic apply(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic pred, input logic [31:0] a, input logic [31:0] b);
    ex_valid_i = v; ex_inst_i = inst; ex_pc_i = pc; ex_predict_jump_i = pred;
    rs1_data_i = a; rs2_data_i = b;
    hold_flag_i = 3'd0; exc_req_i = 1'b0; int_req_i = 1'b0;
    exc_vector_i = 32'h800; int_vector_i = 32'h900;
  endtask

  task automatic idle();
    apply(1'b0, 32'h13, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  // Push the expectation for the next edge, then advance one cycle.
  task automatic step(input logic [2:0] c, input logic [31:0] f, input logic [31:0] t,
                      input logic fl, input int bc, input int mc);
    exp_t e;
    e.due = cyc + 1; e.cause = c; e.from = f; e.to = t; e.flush = fl;
    e.bcnt = bc; e.mcnt = mc; e.bcnt4 = sat4(bc); e.mcnt4 = sat4(mc);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; jtag_reset_i = 1'b0;
    idle();
    @(posedge clk); #1;
    step(NO, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // BEQ taken, predicted not taken
    apply(1, enc_b(3'b000, 13'h020), 32'h100, 0, 5, 5); step(PNBY, 32'h100, 32'h120, 1, 1, 1);
    idle(); step(NO, 32'h100, 32'h120, 1, 1, 1);
    idle(); step(NO, 32'h100, 32'h120, 0, 1, 1);
    // BLT signed taken, correctly predicted
    apply(1, enc_b(3'b100, 13'h020), 32'h200, 1, 32'hFFFF_FFFF, 1);
    step(NO, 32'h100, 32'h120, 0, 2, 1);
    // BLTU same operands not taken, predicted taken
    apply(1, enc_b(3'b110, 13'h020), 32'h200, 1, 32'hFFFF_FFFF, 1);
    step(PYBN, 32'h200, 32'h204, 1, 3, 2);
    idle(); step(NO, 32'h200, 32'h204, 1, 3, 2);
    idle(); step(NO, 32'h200, 32'h204, 0, 3, 2);
    // Mispredicted BNE with exception and interrupt: exception wins, no branch count
    apply(1, enc_b(3'b001, 13'h040), 32'h300, 0, 1, 2);
    exc_req_i = 1; int_req_i = 1;
    step(EXC, 32'h300, 32'h800, 1, 3, 2);
    apply(1, enc_b(3'b000, 13'h020), 32'h304, 0, 5, 5); int_req_i = 1;
    step(NO, 32'h300, 32'h800, 1, 3, 2);
    apply(1, enc_b(3'b000, 13'h020), 32'h304, 0, 5, 5); int_req_i = 1;
    step(NO, 32'h300, 32'h800, 0, 3, 2);
    // Interrupt still pending on first consumed instruction
    apply(1, 32'h13, 32'h308, 0, 0, 0); int_req_i = 1;
    step(INT, 32'h308, 32'h900, 1, 3, 2);
    idle(); step(NO, 32'h308, 32'h900, 1, 3, 2);
    idle(); step(NO, 32'h308, 32'h900, 0, 3, 2);
    // JALR clears bit 0; wrong-path instructions (one with exception) are ignored
    apply(1, enc_jalr(12'h004), 32'h400, 0, 32'h1003, 0);
    step(NOC, 32'h400, 32'h1006, 1, 3, 2);
    apply(1, 32'h13, 32'h404, 0, 0, 0); exc_req_i = 1;
    step(NO, 32'h400, 32'h1006, 1, 3, 2);
    apply(1, enc_b(3'b000, 13'h020), 32'h408, 0, 5, 5);
    step(NO, 32'h400, 32'h1006, 0, 3, 2);
    // JAL with negative offset, then hold stretches the flush to 5 cycles
    apply(1, enc_jal(21'h1FFF00), 32'h500, 0, 0, 0);
    step(NOC, 32'h500, 32'h400, 1, 3, 2);
    for (int i = 0; i < 3; i++) begin
      idle(); hold_flag_i = 3'b001;
      step(NO, 32'h500, 32'h400, 1, 3, 2);
    end
    idle(); step(NO, 32'h500, 32'h400, 1, 3, 2);
    idle(); step(NO, 32'h500, 32'h400, 0, 3, 2);
    // Held instruction in RUN is not consumed
    apply(1, enc_b(3'b000, 13'h020), 32'h580, 0, 5, 5); hold_flag_i = 3'b010;
    step(NO, 32'h500, 32'h400, 0, 3, 2);
    // funct3 010 under branch opcode is not a branch
    apply(1, enc_b(3'b010, 13'h020), 32'h590, 1, 1, 2);
    step(NO, 32'h500, 32'h400, 0, 3, 2);
    // BGE signed taken, negative offset
    apply(1, enc_b(3'b101, 13'h1FF8), 32'h600, 0, 1, 32'hFFFF_FFFF);
    step(PNBY, 32'h600, 32'h5F8, 1, 4, 3);
    idle(); step(NO, 32'h600, 32'h5F8, 1, 4, 3);
    idle(); step(NO, 32'h600, 32'h5F8, 0, 4, 3);
    // BGEU not taken, predicted taken; then reset mid-flush
    apply(1, enc_b(3'b111, 13'h020), 32'h700, 1, 1, 2);
    step(PYBN, 32'h700, 32'h704, 1, 5, 4);
    idle(); rst_n = 1'b0;
    step(NO, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    idle(); step(NO, 0, 0, 0, 0, 0);
    // Repeated mispredicts: the 4-bit copy saturates at 0xF
    for (int i = 1; i <= 17; i++) begin
      apply(1, enc_b(3'b000, 13'h020), 32'h100, 0, 5, 5);
      step(PNBY, 32'h100, 32'h120, 1, i, i);
      idle(); step(NO, 32'h100, 32'h120, 1, i, i);
      idle(); step(NO, 32'h100, 32'h120, 0, i, i);
    end
    // JTAG reset has the same effect as rst_n
    apply(1, enc_b(3'b000, 13'h020), 32'h100, 0, 5, 5);
    step(PNBY, 32'h100, 32'h120, 1, 18, 18);
    idle(); jtag_reset_i = 1'b1;
    step(NO, 0, 0, 0, 0, 0);
    jtag_reset_i = 1'b0;
    idle(); step(NO, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
